mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
- DATA_WIDTH, 32, memory data width.
- ADDR_WIDTH, 5, memory address width.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles to wait for mem_access_complete.
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  permits new grants.
- req_valid  in  NUM_REQ  per-requester access request, held until done/error.
- req_type  in  NUM_REQ  per-requester type, 1=write, 0=read.
- req_address  in  NUM_REQ x ADDR_WIDTH  per-requester address.
- req_write_data  in  NUM_REQ x DATA_WIDTH  per-requester write data.
- req_done  out  NUM_REQ  one-cycle completion pulse.
- req_error  out  NUM_REQ  one-cycle timeout pulse.
- req_read_data  out  DATA_WIDTH  read data, valid with req_done.
- mem_access_request  out  1  memory request, level.
- mem_access_type  out  1  1=write, 0=read.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_write_data  out  DATA_WIDTH  memory write data.
- mem_read_data  in  DATA_WIDTH  memory read data.
- mem_access_complete  in  1  one-cycle memory completion.
- grant_id  out  clog2(NUM_REQ)  index of current or last grantee.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS, DONE; all outputs registered.
REQ-004 IDLE SHALL grant when enable=1 and any req_valid=1; otherwise it SHALL remain in IDLE.
REQ-005 Grant selection SHALL be round-robin: the first valid index after last_grant, wrapping from NUM_REQ-1 to 0.
REQ-006 On grant at cycle N, the block SHALL capture the grantee's type, address and write data into the mem_* outputs, set grant_id, and assert mem_access_request from cycle N+1.
REQ-007 In ACCESS, mem_access_request and all mem_* fields SHALL hold stable until mem_access_complete or timeout.
REQ-008 On mem_access_complete at cycle M, the block SHALL:
- capture mem_read_data into req_read_data (reads only; writes leave it unchanged),
- deassert mem_access_request at M+1,
- pulse req_done[grant_id] during M+1 (state DONE).
REQ-009 The watchdog counter SHALL clear on entry to ACCESS and increment each ACCESS cycle.
REQ-010 If the watchdog reaches TIMEOUT-1 without completion, the block SHALL deassert the request and pulse req_error[grant_id] in DONE instead of req_done.
REQ-011 If mem_access_complete coincides with the timeout cycle, completion SHALL win: req_done pulses and req_error does not.
REQ-012 DONE SHALL last exactly one cycle, update last_grant to grant_id, and return to IDLE; no grant is made in DONE.
REQ-013 enable=0 SHALL block new grants only; an in-flight access SHALL complete normally.
REQ-014 mem_access_complete outside ACCESS SHALL be ignored.
REQ-015 A requester dropping req_valid mid-access SHALL NOT abort the access.
REQ-016 At most one bit of req_done|req_error SHALL be high in any cycle.

Reset
REQ-017 While reset=0 at a rising edge, the block SHALL:
- enter IDLE,
- clear all outputs to zero,
- set last_grant to NUM_REQ-1 (requester 0 wins first),
- clear the watchdog.
REQ-018 Reset during ACCESS SHALL abandon the access, deassert mem_access_request next cycle, and produce no done/error pulse.

Structure
REQ-019 The state enum and the type encodings (write=1, read=0) SHALL be defined in ocp_pkg.
REQ-020 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, last_grant; outputs: grant index, grant valid).

Verification
REQ-021 Single read: req_valid[2]=1, type=0, address=5'h0A; complete 3 cycles after request with mem_read_data=32'hDEADBEEF -> mem_address=0A, req_done[2] pulse, req_read_data=DEADBEEF.
REQ-022 All four requesters valid continuously, zero-wait memory -> grant order 0,1,2,3,0, each access 3 cycles IDLE->ACCESS->DONE.
REQ-023 Memory never completes, TIMEOUT=64 -> mem_access_request high 64 cycles, then req_error[grantee] one pulse and no req_done.
REQ-024 Complete on the exact timeout cycle -> req_done pulses, req_error stays 0.
REQ-025 Reset asserted mid-ACCESS -> all outputs 0 next cycle, no done/error pulse, next grant goes to requester 0.
REQ-026 enable dropped during ACCESS with other requests pending -> current access completes, no further grant until enable=1.

Source files
------------

// File: rtl/ocp_pkg.sv
// rtl/ocp_pkg.sv - shared state and access-type encodings for the memory port arbiter
package ocp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  localparam logic ACC_WRITE = 1'b1;
  localparam logic ACC_READ  = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request after last_grant, wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_valid
);

  int idx;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    // Scan starts one past the previous winner so it gets lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_valid && req[idx]) begin
        grant_idx   = IDW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter granting one requester at a time onto a single memory port
module mem_port_arbiter
  import ocp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_type,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_address,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_write_data,
  output logic [NUM_REQ-1:0]                   req_done,
  output logic [NUM_REQ-1:0]                   req_error,
  output logic [DATA_WIDTH-1:0]                req_read_data,
  output logic                                 mem_access_request,
  output logic                                 mem_access_type,
  output logic [ADDR_WIDTH-1:0]                mem_address,
  output logic [DATA_WIDTH-1:0]                mem_write_data,
  input  logic [DATA_WIDTH-1:0]                mem_read_data,
  input  logic                                 mem_access_complete,
  output logic [IDW-1:0]                       grant_id,
  output logic                                 busy
);

  localparam int             WDW       = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  arb_state_t                state_q, state_d;
  logic [IDW-1:0]            last_grant_q, last_grant_d;
  logic [WDW-1:0]            wdog_q, wdog_d;

  logic [NUM_REQ-1:0]        done_d, error_d;
  logic [DATA_WIDTH-1:0]     rdata_d;
  logic                      mem_req_d, mem_type_d, busy_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_d;
  logic [IDW-1:0]            grant_d;

  logic [IDW-1:0]            arb_idx;
  logic                      arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_arbiter (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      last_grant_q       <= IDW'(NUM_REQ - 1);
      wdog_q             <= '0;
      req_done           <= '0;
      req_error          <= '0;
      req_read_data      <= '0;
      mem_access_request <= 1'b0;
      mem_access_type    <= 1'b0;
      mem_address        <= '0;
      mem_write_data     <= '0;
      grant_id           <= '0;
      busy               <= 1'b0;
    end else begin
      state_q            <= state_d;
      last_grant_q       <= last_grant_d;
      wdog_q             <= wdog_d;
      req_done           <= done_d;
      req_error          <= error_d;
      req_read_data      <= rdata_d;
      mem_access_request <= mem_req_d;
      mem_access_type    <= mem_type_d;
      mem_address        <= mem_addr_d;
      mem_write_data     <= mem_wdata_d;
      grant_id           <= grant_d;
      busy               <= busy_d;
    end
  end

  // Computes the next value of every registered output; pulses default low.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    done_d       = '0;
    error_d      = '0;
    rdata_d      = req_read_data;
    mem_req_d    = mem_access_request;
    mem_type_d   = mem_access_type;
    mem_addr_d   = mem_address;
    mem_wdata_d  = mem_write_data;
    grant_d      = grant_id;

    case (state_q)
      ST_IDLE: begin
        if (enable && arb_valid) begin
          state_d     = ST_ACCESS;
          grant_d     = arb_idx;
          mem_req_d   = 1'b1;
          mem_type_d  = req_type[arb_idx];
          mem_addr_d  = req_address[arb_idx];
          mem_wdata_d = req_write_data[arb_idx];
          wdog_d      = '0;
        end
      end
      ST_ACCESS: begin
        // Completion is tested first so it wins over a same-cycle timeout.
        if (mem_access_complete) begin
          if (mem_access_type == ACC_READ) begin
            rdata_d = mem_read_data;
          end
          mem_req_d         = 1'b0;
          done_d[grant_id]  = 1'b1;
          state_d           = ST_DONE;
        end else if (wdog_q == WDOG_LAST) begin
          mem_req_d         = 1'b0;
          error_d[grant_id] = 1'b1;
          state_d           = ST_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_DONE: begin
        last_grant_d = grant_id;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 4;
  localparam int TO = 64;
  localparam int IW = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_type;
  logic [N-1:0][AW-1:0]  req_address;
  logic [N-1:0][DW-1:0]  req_write_data;
  logic [N-1:0]          req_done;
  logic [N-1:0]          req_error;
  logic [DW-1:0]         req_read_data;
  logic                  mem_access_request;
  logic                  mem_access_type;
  logic [AW-1:0]         mem_address;
  logic [DW-1:0]         mem_write_data;
  logic [DW-1:0]         mem_read_data;
  logic                  mem_access_complete;
  logic [IW-1:0]         grant_id;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int model_last = N - 1;
  logic [DW-1:0] model_rdata = '0;

  mem_port_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REQ    (N),
    .TIMEOUT    (TO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .req_valid           (req_valid),
    .req_type            (req_type),
    .req_address         (req_address),
    .req_write_data      (req_write_data),
    .req_done            (req_done),
    .req_error           (req_error),
    .req_read_data       (req_read_data),
    .mem_access_request  (mem_access_request),
    .mem_access_type     (mem_access_type),
    .mem_address         (mem_address),
    .mem_write_data      (mem_write_data),
    .mem_read_data       (mem_read_data),
    .mem_access_complete (mem_access_complete),
    .grant_id            (grant_id),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] onehot(input int w);
    return 64'(1) << w;
  endfunction

  // Round-robin rule: first valid index after the previous winner, wrapping.
  function automatic int predict_winner(input logic [N-1:0] m);
    int w = -1;
    for (int i = 1; i <= N; i++) begin
      if (w < 0 && m[(model_last + i) % N]) w = (model_last + i) % N;
    end
    return w;
  endfunction

  // One access from an idle arbiter: memory answers in ACCESS cycle 'lat'
  // (0-based); lat beyond TO-1 means the memory never answers in time.
  task automatic run_txn(input logic [N-1:0] m, input int lat, input logic [DW-1:0] rd);
    int w, hi, exp_hi;
    bit timed_out;
    logic [AW-1:0] exp_addr;
    w         = predict_winner(m);
    timed_out = (lat > TO - 1);
    exp_hi    = timed_out ? TO : lat + 1;
    req_valid = m;
    @(negedge clk);
    exp_addr = req_address[w];
    chk("grant_request", 64'(mem_access_request), 64'(1));
    chk("grant_id", 64'(grant_id), 64'(w));
    chk("mem_type", 64'(mem_access_type), 64'(req_type[w]));
    chk("mem_address", 64'(mem_address), 64'(exp_addr));
    chk("mem_wdata", 64'(mem_write_data), 64'(req_write_data[w]));
    chk("busy_access", 64'(busy), 64'(1));
    hi = 0;
    while (mem_access_request && hi < 200) begin
      hi++;
      mem_access_complete = (hi - 1 == lat);
      mem_read_data       = (hi - 1 == lat) ? rd : DW'($urandom);
      if (hi == 2) req_valid[w] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (mem_access_request) chk("addr_stable", 64'(mem_address), 64'(exp_addr));
    end
    mem_access_complete = 1'b0;
    chk("request_cycles", 64'(hi), 64'(exp_hi));
    if (!timed_out && req_type[w] == 1'b0) model_rdata = rd;
    chk("done_pulse", 64'(req_done), timed_out ? 64'(0) : onehot(w));
    chk("error_pulse", 64'(req_error), timed_out ? onehot(w) : 64'(0));
    chk("read_data", 64'(req_read_data), 64'(model_rdata));
    chk("busy_done", 64'(busy), 64'(1));
    model_last          = w;
    req_valid           = '0;
    mem_access_complete = (lat == TO);
    @(negedge clk);
    mem_access_complete = 1'b0;
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_pulses", 64'({req_done, req_error}), 64'(0));
    chk("idle_request", 64'(mem_access_request), 64'(0));
  endtask

  task automatic randomize_fields();
    req_type = N'($urandom);
    for (int i = 0; i < N; i++) begin
      req_address[i]    = AW'($urandom_range(0, (1 << AW) - 1));
      req_write_data[i] = DW'($urandom);
    end
  endtask

  initial begin
    int w, r, lat;
    reset = 1'b0; enable = 1'b1; req_valid = '0; req_type = '0;
    req_address = '0; req_write_data = '0; mem_read_data = '0; mem_access_complete = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({req_done, req_error, mem_access_request, mem_access_type, busy, grant_id}), 64'(0));
    chk("reset_data", 64'({req_read_data, mem_address}), 64'(0));
    chk("reset_wdata", 64'(mem_write_data), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // All requesters valid, zero-wait memory: 0,1,2,3,0 in 3-cycle slots.
    req_type = '0; mem_read_data = 32'h1234_5678; req_valid = '1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      case (c % 3)
        0: begin
          chk("rr_request", 64'(mem_access_request), 64'(1));
          chk("rr_grant", 64'(grant_id), 64'((c / 3) % N));
        end
        1: begin
          chk("rr_done", 64'(req_done), onehot((c / 3) % N));
          chk("rr_rdata", 64'(req_read_data), 64'(32'h1234_5678));
        end
        default: chk("rr_idle", 64'(busy), 64'(0));
      endcase
      mem_access_complete = mem_access_request;
    end
    req_valid = '0; mem_access_complete = 1'b0;
    model_last = 0; model_rdata = 32'h1234_5678;
    @(negedge clk);

    // Single read from requester 2.
    randomize_fields();
    req_type[2] = 1'b0; req_address[2] = 5'h0A;
    run_txn(4'b0100, 3, 32'hDEAD_BEEF);
    chk("read_deadbeef", 64'(req_read_data), 64'(32'hDEAD_BEEF));

    // Memory never answers, then answers exactly on the timeout cycle.
    randomize_fields();
    run_txn(4'b0001, 1000, 32'h0);
    randomize_fields();
    req_type[1] = 1'b0;
    run_txn(4'b0010, TO - 1, 32'hC0FF_EE01);

    // Reset in the middle of an access.
    randomize_fields();
    req_valid = '1;
    repeat (3) @(negedge clk);
    chk("pre_reset_request", 64'(mem_access_request), 64'(1));
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_ctrl", 64'({req_done, req_error, mem_access_request, busy, grant_id}), 64'(0));
    chk("midreset_data", 64'({req_read_data, mem_address, mem_access_type}), 64'(0));
    reset = 1'b1; model_last = N - 1; model_rdata = '0;
    run_txn(4'b1111, 2, 32'hA5A5_0001);

    // enable dropped during an access with other requests pending.
    randomize_fields();
    w = predict_winner(4'b1111);
    req_valid = '1;
    @(negedge clk);
    chk("en_grant", 64'(grant_id), 64'(w));
    enable = 1'b0; mem_access_complete = 1'b1; mem_read_data = 32'h5A5A_0002;
    @(negedge clk);
    mem_access_complete = 1'b0;
    chk("en_done", 64'(req_done), onehot(w));
    if (req_type[w] == 1'b0) model_rdata = 32'h5A5A_0002;
    model_last = w;
    for (int c = 0; c < 4; c++) begin
      mem_access_complete = c[0];
      @(negedge clk);
      chk("en_blocked", 64'({busy, mem_access_request, req_done, req_error}), 64'(0));
    end
    mem_access_complete = 1'b0;
    chk("en_rdata_kept", 64'(req_read_data), 64'(model_rdata));
    enable = 1'b1;
    run_txn(4'b1111, 1, 32'h0BAD_F00D);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      randomize_fields();
      r = $urandom_range(0, 9);
      lat = (r < 7) ? $urandom_range(0, 5) : (r == 7) ? TO - 1 : (r == 8) ? TO : TO - 2;
      run_txn(N'($urandom_range(1, (1 << N) - 1)), lat, DW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
